// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: issues one AGU load/store/cache-op on the dcache req/addr_ok/data_ok bus and stalls the pipeline until data_ok.
// Optional MEM_PERF_CNT_EN adds handshake and stall-cycle counters. Load result is registered and valid one cycle after data_ok.
module mem_req_ctrl #(
    parameter bit KSEG_XLATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ce_i,
    input  logic [31:0] v_addr_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic        cache_op_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_wdata_o,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0] perf_req_cnt_o,
    output logic [31:0] perf_stall_cnt_o,
`endif
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        flushed_q, flushed_d;
    logic [31:0] addr_q, wdata_q;
    logic        wr_q, sign_q, cop_q;
    logic [1:0]  size_q;
    logic        ld_valid_q;
    logic [31:0] ld_data_q;
    logic        capture, done, ld_ok;
    logic [31:0] rshift, ld_ext;

    assign capture = (state_q == S_IDLE) && ce_i && !flush;
    assign done    = (state_q == S_DATA) && data_data_ok_i;
    // A flush arriving together with data_ok still kills the load result.
    assign ld_ok   = done && !flushed_q && !flush && !wr_q && !cop_q;

    always_comb begin
        state_d   = state_q;
        flushed_d = flushed_q;
        case (state_q)
            S_IDLE: if (capture) state_d = S_ADDR;
            S_ADDR: begin
                if (flush) flushed_d = 1'b1;
                if (data_addr_ok_i) state_d = S_DATA;
            end
            S_DATA: begin
                if (flush) flushed_d = 1'b1;
                if (data_data_ok_i) begin
                    state_d   = S_IDLE;
                    flushed_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                flushed_d = 1'b0;
            end
        endcase
    end

    // Once flushed, the pipeline is free; a new access only stalls until the drain ends.
    always_comb begin
        stall_o = ce_i && !flush;
        if (!flushed_q) begin
            if (state_q == S_ADDR)      stall_o = 1'b1;
            else if (state_q == S_DATA) stall_o = !data_data_ok_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            flushed_q  <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wr_q       <= 1'b0;
            sign_q     <= 1'b0;
            cop_q      <= 1'b0;
            size_q     <= 2'b00;
            ld_valid_q <= 1'b0;
            ld_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            flushed_q  <= flushed_d;
            ld_valid_q <= ld_ok;
            if (ld_ok) ld_data_q <= ld_ext;
            if (capture) begin
                addr_q  <= v_addr_i;
                wdata_q <= wdata_i;
                wr_q    <= wr_i;
                sign_q  <= sign_ext_i;
                cop_q   <= cache_op_i;
                size_q  <= size_i;
            end
        end
    end

    assign rshift = data_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   ld_ext = {{24{sign_q & rshift[7]}}, rshift[7:0]};
            2'b01:   ld_ext = {{16{sign_q & rshift[15]}}, rshift[15:0]};
            default: ld_ext = data_rdata_i;
        endcase
    end

    always_comb begin
        data_wstrb_o = 4'b0000;
        if (wr_q && !cop_q) begin
            case (size_q)
                2'b00:   data_wstrb_o = 4'b0001 << addr_q[1:0];
                2'b01:   data_wstrb_o = 4'b0011 << {addr_q[1], 1'b0};
                default: data_wstrb_o = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   data_wdata_o = {4{wdata_q[7:0]}};
            2'b01:   data_wdata_o = {2{wdata_q[15:0]}};
            default: data_wdata_o = wdata_q;
        endcase
    end

    assign data_addr_o = (KSEG_XLATE && (addr_q[31:30] == 2'b10)) ? (addr_q & 32'h1FFF_FFFF) : addr_q;
    assign data_req_o  = (state_q == S_ADDR);
    assign data_wr_o   = wr_q | cop_q;
    assign data_size_o = size_q;
    assign ld_valid_o  = ld_valid_q;
    assign ld_data_o   = ld_data_q;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_req_q, perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_q   <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if ((state_q == S_ADDR) && data_addr_ok_i) perf_req_q <= perf_req_q + 32'd1;
            if (stall_o) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_req_cnt_o   = perf_req_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif
endmodule
